keypad_emulator: RTL and testbench

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_emulator.sv | 184 ++++++++++++++++++
 tb/tb_keypad_emulator.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module   : keypad_emulator
// Brief    : Emulates a human pressing one key of a 4x3 matrix keypad,
//            with contact bounce on press and release.
// Revision : 1.0
// ============================================================================
module keypad_emulator #(
    parameter int BOUNCE_PERIOD  = 4,
    parameter int BOUNCE_TOGGLES = 6,
    parameter int HOLD_CYCLES    = 2000000,
    parameter int GAP_CYCLES     = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keyboard_rows,
    output logic [2:0] keyboard_cols,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_key,
    output logic       cmd_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int MAX_AB = (BOUNCE_PERIOD > BOUNCE_TOGGLES) ? BOUNCE_PERIOD : BOUNCE_TOGGLES;
    localparam int MAX_CD = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAXP + 1);

    localparam logic [CW-1:0] BP_LAST   = CW'(BOUNCE_PERIOD - 1);
    localparam logic [CW-1:0] TOG_N     = CW'(BOUNCE_TOGGLES);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS_BNC = 3'd1,
        HOLD      = 3'd2,
        REL_BNC   = 3'd3,
        GAP       = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] tog_q, tog_d;
    logic          contact_q, contact_d;
    logic [3:0]    key_q, key_d;
    logic          err_q, err_d;
    logic          done_q, done_d;

    logic [1:0]    key_row;
    logic [1:0]    key_col;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tog_q     <= '0;
            contact_q <= 1'b0;
            key_q     <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tog_q     <= tog_d;
            contact_q <= contact_d;
            key_q     <= key_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tog_d     = tog_q;
        contact_d = contact_q;
        key_d     = key_q;
        err_d     = err_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d     = '0;
                tog_d     = '0;
                contact_d = 1'b0;
                if (cmd_valid) begin
                    key_d = cmd_key;
                    if (cmd_key <= 4'd11) begin
                        state_d   = PRESS_BNC;
                        contact_d = 1'b1;
                        err_d     = 1'b0;
                    end else begin
                        state_d = GAP;
                        err_d   = 1'b1;
                    end
                end
            end
            // Both bounce phases share one schedule; the exit level differs.
            PRESS_BNC, REL_BNC: begin
                if (cnt_q == BP_LAST) begin
                    cnt_d = '0;
                    if (tog_q == TOG_N) begin
                        tog_d = '0;
                        if (state_q == PRESS_BNC) begin
                            state_d   = HOLD;
                            contact_d = 1'b1;
                        end else begin
                            state_d   = GAP;
                            contact_d = 1'b0;
                        end
                    end else begin
                        tog_d     = tog_q + CNT_ONE;
                        contact_d = ~contact_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d     = '0;
                    state_d   = REL_BNC;
                    contact_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            GAP: begin
                contact_d = 1'b0;
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                tog_d     = '0;
                contact_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        key_row = 2'd0;
        key_col = 2'd0;
        unique case (key_q)
            4'd1:    begin key_row = 2'd0; key_col = 2'd0; end
            4'd2:    begin key_row = 2'd0; key_col = 2'd1; end
            4'd3:    begin key_row = 2'd0; key_col = 2'd2; end
            4'd4:    begin key_row = 2'd1; key_col = 2'd0; end
            4'd5:    begin key_row = 2'd1; key_col = 2'd1; end
            4'd6:    begin key_row = 2'd1; key_col = 2'd2; end
            4'd7:    begin key_row = 2'd2; key_col = 2'd0; end
            4'd8:    begin key_row = 2'd2; key_col = 2'd1; end
            4'd9:    begin key_row = 2'd2; key_col = 2'd2; end
            4'd10:   begin key_row = 2'd3; key_col = 2'd0; end
            4'd0:    begin key_row = 2'd3; key_col = 2'd1; end
            4'd11:   begin key_row = 2'd3; key_col = 2'd2; end
            default: begin key_row = 2'd0; key_col = 2'd0; end
        endcase
    end

    // Invalid codes never close the contact, so the decoder default is harmless.
    always_comb begin
        keyboard_cols = 3'b000;
        if (!rst && contact_q && keyboard_rows[key_row])
            keyboard_cols[key_col] = 1'b1;
    end

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE) && !rst;
    assign done      = done_q && !rst;
    assign err       = err_q && !rst;

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_emulator
// Brief    : Directed self-checking bench for keypad_emulator.
// Revision : 1.0
// ============================================================================
module tb_keypad_emulator;

    logic       clk;
    logic       rst;
    logic [3:0] keyboard_rows;
    logic [2:0] keyboard_cols;
    logic       cmd_valid;
    logic [3:0] cmd_key;
    logic       cmd_ready;
    logic       busy;
    logic       done;
    logic       err;

    int n_pass;
    int n_total;
    int n_done;

    keypad_emulator #(
        .BOUNCE_PERIOD (2),
        .BOUNCE_TOGGLES(4),
        .HOLD_CYCLES   (10),
        .GAP_CYCLES    (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .keyboard_rows(keyboard_rows),
        .keyboard_cols(keyboard_cols),
        .cmd_valid    (cmd_valid),
        .cmd_key      (cmd_key),
        .cmd_ready    (cmd_ready),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Contact level i cycles after acceptance of a valid key: 10 press-bounce
    // cycles, 10 hold, 10 release-bounce, 5 gap.
    function automatic bit closed(input int i);
        if (i < 10)      return ((i / 2) % 2) == 0;
        else if (i < 20) return 1'b1;
        else if (i < 30) return ((i - 20) / 2) % 2 == 1;
        else             return 1'b0;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        n_pass = 0; n_total = 0; n_done = 0;
        rst = 1'b1; keyboard_rows = 4'b0010; cmd_valid = 1'b0; cmd_key = 4'd0;
        tick(); tick();
        #1;
        chk("rst_cols",  keyboard_cols, 3'b000);
        chk("rst_busy",  busy, 1'b0);
        chk("rst_ready", cmd_ready, 1'b0);
        chk("rst_done",  done, 1'b0);

        // Key 5, row 1 held.
        rst = 1'b0;
        #1;
        chk("ready_after_rst", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_key = 4'd5;
        for (int i = 0; i < 35; i++) begin
            tick();
            cmd_valid = 1'b0;
            #1;
            chk("k5_seq", {busy, done, keyboard_cols}, {1'b1, 1'b0, closed(i) ? 3'b010 : 3'b000});
        end
        tick(); #1;
        chk("k5_done", {done, err, busy, cmd_ready}, 4'b1001);

        // Key 11, rotating rows; accepted in the done cycle.
        cmd_valid = 1'b1; cmd_key = 4'd11;
        for (int i = 0; i < 35; i++) begin
            tick();
            cmd_valid = 1'b0;
            keyboard_rows = 4'b0001 << (i % 4);
            #1;
            chk("k11_cols", keyboard_cols,
                (closed(i) && keyboard_rows == 4'b1000) ? 3'b100 : 3'b000);
        end
        tick(); #1;
        chk("k11_done", {done, err}, 2'b10);

        // Invalid key 13: contact stays open, err with done.
        keyboard_rows = 4'b1111;
        cmd_valid = 1'b1; cmd_key = 4'd13;
        for (int i = 0; i < 5; i++) begin
            tick();
            cmd_valid = 1'b0;
            #1;
            chk("k13_gap", {busy, done, keyboard_cols}, 5'b10000);
        end
        tick(); #1;
        chk("k13_done", {done, err, busy}, 3'b110);

        // Key 2 with key 7 requested during HOLD.
        tick();
        keyboard_rows = 4'b0001;
        cmd_valid = 1'b1; cmd_key = 4'd2;
        n_done = 0;
        for (int i = 0; i < 38; i++) begin
            tick();
            cmd_valid = 1'b0;
            if (i == 12) begin
                cmd_valid = 1'b1; cmd_key = 4'd7;
            end
            #1;
            if (done) n_done++;
            if (i == 12) chk("k7_ready", cmd_ready, 1'b0);
            if (i < 35)
                chk("k2_seq", {busy, keyboard_cols}, {1'b1, closed(i) ? 3'b010 : 3'b000});
            if (i == 35) chk("k2_done", {done, err}, 2'b10);
        end
        chk("k2_ndone", n_done, 1);

        // Key 9, reset pulsed in HOLD.
        keyboard_rows = 4'b0100;
        cmd_valid = 1'b1; cmd_key = 4'd9;
        for (int i = 0; i < 15; i++) begin
            tick();
            cmd_valid = 1'b0;
        end
        #1;
        chk("k9_hold", keyboard_cols, 3'b100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("k9_abort", {keyboard_cols, busy, cmd_ready}, 5'b00001);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick(); #1;
            if (done) n_done++;
        end
        chk("k9_nodone", n_done, 0);

        // Key 0 back-to-back with cmd_valid held.
        keyboard_rows = 4'b1000;
        cmd_valid = 1'b1; cmd_key = 4'd0;
        for (int i = 0; i < 36; i++) begin
            tick(); #1;
            if (i == 0) chk("k0_first", keyboard_cols, 3'b010);
        end
        chk("k0_done", {done, err, cmd_ready}, 3'b101);
        tick(); #1;
        chk("k0_again", {busy, keyboard_cols}, 4'b1010);
        cmd_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
